// File: rtl/pipe_elastic_chain.sv
// pipe_elastic_chain: elastic valid/ready register chain with bubble collapse, per-slot kill,
// flush, and occupancy/dropped debug counters.
module pipe_elastic_chain #(
  parameter  int WIDTH  = 16,
  parameter  int STAGES = 4,
  parameter  int CNT_W  = 16,
  localparam int OCC_W  = $clog2(STAGES + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  input  logic [STAGES-1:0] kill_mask,
  input  logic              flush,
  output logic [OCC_W-1:0]  occupancy,
  output logic [CNT_W-1:0]  dropped
);
  logic [STAGES-1:0] v_q, v_d, vk, r, gone;
  logic [WIDTH-1:0]  d_q [STAGES];
  logic [WIDTH-1:0]  d_d [STAGES];
  logic [OCC_W-1:0]  occupancy_q, occupancy_d, drop_n;
  logic [CNT_W-1:0]  dropped_q, dropped_d;
  logic [CNT_W:0]    drop_sum;
  always_comb begin
    vk = v_q & ~kill_mask & {STAGES{~flush}};
    gone = v_q & (kill_mask | {STAGES{flush}});
    r[STAGES-1] = out_ready | ~vk[STAGES-1];
    for (int i = STAGES - 2; i >= 0; i--) r[i] = ~vk[i] | r[i+1];
    v_d[0] = r[0] ? in_valid & ~flush : vk[0];
    d_d[0] = (r[0] & in_valid & ~flush) ? in_data : d_q[0];
    // a killed slot reports ready, so an arrival overwrites the squashed item
    for (int i = 1; i < STAGES; i++) begin
      v_d[i] = r[i] ? vk[i-1] : vk[i];
      d_d[i] = (r[i] & vk[i-1]) ? d_q[i-1] : d_q[i];
    end
    occupancy_d = '0;
    drop_n = '0;
    for (int i = 0; i < STAGES; i++) begin
      occupancy_d = occupancy_d + OCC_W'(v_d[i]);
      drop_n = drop_n + OCC_W'(gone[i]);
    end
    drop_sum = {1'b0, dropped_q} + (CNT_W + 1)'(drop_n);
    dropped_d = drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v_q <= '0;
      d_q <= '{default: '0};
      occupancy_q <= '0;
      dropped_q <= '0;
    end else begin
      v_q <= v_d;
      d_q <= d_d;
      occupancy_q <= occupancy_d;
      dropped_q <= dropped_d;
    end
  end
  assign in_ready  = r[0] & ~flush;
  assign out_valid = vk[STAGES-1];
  assign out_data  = d_q[STAGES-1];
  assign occupancy = occupancy_q;
  assign dropped   = dropped_q;
endmodule

// File: tb/tb_pipe_elastic_chain.sv
// tb_pipe_elastic_chain: directed scoreboard bench; a 3-bit-counter twin exercises saturation.
module tb_pipe_elastic_chain;
  localparam int W = 16, S = 4;
  logic clk = 0, rst = 0, in_valid = 0, out_ready = 0, flush = 0;
  logic [W-1:0] in_data = '0;
  logic [S-1:0] kill_mask = '0;
  logic in_ready, out_valid, in_ready_s, out_valid_s;
  logic [W-1:0] out_data, out_data_s;
  logic [2:0] occupancy, occupancy_s, dropped_s;
  logic [15:0] dropped, drop0;
  logic [W-1:0] exp_q [$];
  int checks = 0, failures = 0, first_out;

  always #5 clk = ~clk;

  pipe_elastic_chain #(.WIDTH(W), .STAGES(S), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .kill_mask(kill_mask), .flush(flush), .occupancy(occupancy), .dropped(dropped));

  pipe_elastic_chain #(.WIDTH(W), .STAGES(S), .CNT_W(3)) u_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s), .in_data(in_data),
    .out_valid(out_valid_s), .out_ready(out_ready), .out_data(out_data_s),
    .kill_mask(kill_mask), .flush(flush), .occupancy(occupancy_s), .dropped(dropped_s));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) if (rst) begin
    if (out_valid && out_ready) begin
      check("sb_avail", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) check("sb_data", 32'(out_data), 32'(exp_q.pop_front()));
    end
    if (in_valid && in_ready) exp_q.push_back(in_data);
  end

  task automatic fill_and_flush(input logic [15:0] base);
    out_ready = 0;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1;
      in_data = base + 16'(k);
      tick();
    end
    flush = 1;
    in_valid = 1;
    in_data = 16'hEEEE;
    drop0 = dropped;
    @(negedge clk);
    check("flush_in_ready", 32'(in_ready), 0);
    check("flush_out_valid", 32'(out_valid), 0);
    check("flush_occ_pre", 32'(occupancy), 4);
    tick();
    flush = 0;
    in_valid = 0;
    exp_q.delete();
    @(negedge clk);
    check("flush_occ", 32'(occupancy), 0);
    check("flush_dropped", 32'(dropped), 32'(drop0) + 4);
    tick();
  endtask

  initial begin
    #12;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_occ", 32'(occupancy), 0);
    check("rst_dropped", 32'(dropped), 0);
    check("rst_out_data", 32'(out_data), 0);
    check("rst_in_ready", 32'(in_ready), 1);
    tick();
    rst = 1;
    // latency and full throughput
    out_ready = 1;
    first_out = -1;
    for (int c = 0; c < 12; c++) begin
      in_valid = c < 8;
      in_data = 16'(c + 1);
      @(negedge clk);
      if (c < 8) check("tp_in_ready", 32'(in_ready), 1);
      if (out_valid && first_out < 0) first_out = c;
      tick();
    end
    in_valid = 0;
    check("tp_latency", 32'(first_out), 4);
    check("tp_drained", 32'(exp_q.size()), 0);
    // fill under backpressure, then release
    out_ready = 0;
    for (int k = 0; k < 5; k++) begin
      in_valid = 1;
      in_data = 16'hA000 + 16'(k);
      @(negedge clk);
      check("fill_in_ready", 32'(in_ready), 32'(k < 4));
      if (k == 4) begin
        check("fill_occ", 32'(occupancy), 4);
        check("fill_head", 32'(out_data), 32'hA000);
      end
      tick();
    end
    in_valid = 0;
    out_ready = 1;
    repeat (4) tick();
    @(negedge clk);
    check("fill_occ_drained", 32'(occupancy), 0);
    check("fill_sb_empty", 32'(exp_q.size()), 0);
    tick();
    // bubble collapse with slots {1,0,0,1}
    out_ready = 0;
    for (int k = 0; k < 4; k++) begin
      in_valid = (k == 0 || k == 3);
      in_data = (k == 0) ? 16'hB001 : 16'hB002;
      tick();
    end
    in_valid = 1;
    in_data = 16'hB003;
    @(negedge clk);
    check("bub_occ_pre", 32'(occupancy), 2);
    check("bub_in_ready", 32'(in_ready), 1);
    tick();
    in_valid = 0;
    @(negedge clk);
    check("bub_occ", 32'(occupancy), 3);
    tick();
    out_ready = 1;
    repeat (6) tick();
    @(negedge clk);
    check("bub_sb_empty", 32'(exp_q.size()), 0);
    tick();
    // kill the item sitting in slot 1
    out_ready = 0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1;
      in_data = (k == 0) ? 16'h1111 : (k == 1) ? 16'h1234 : 16'h5555;
      tick();
    end
    in_valid = 0;
    kill_mask = 4'b0010;
    drop0 = dropped;
    @(negedge clk);
    check("kill_occ_pre", 32'(occupancy), 3);
    tick();
    kill_mask = '0;
    for (int i = 0; i < exp_q.size(); i++)
      if (exp_q[i] == 16'h1234) begin
        exp_q.delete(i);
        break;
      end
    @(negedge clk);
    check("kill_dropped", 32'(dropped), 32'(drop0) + 1);
    check("kill_occ", 32'(occupancy), 2);
    tick();
    out_ready = 1;
    repeat (6) tick();
    @(negedge clk);
    check("kill_sb_empty", 32'(exp_q.size()), 0);
    tick();
    // flush twice; the 3-bit twin must stop at 7
    fill_and_flush(16'hF000);
    check("sat_first", 32'(dropped_s), 5);
    fill_and_flush(16'hF100);
    check("sat_clamp", 32'(dropped_s), 7);
    check("main_dropped9", 32'(dropped), 9);
    in_valid = 1;
    in_data = 16'hC0DE;
    tick();
    in_valid = 0;
    kill_mask = 4'b0001;
    tick();
    kill_mask = '0;
    exp_q.delete();
    @(negedge clk);
    check("sat_hold", 32'(dropped_s), 7);
    check("main_dropped10", 32'(dropped), 10);
    check("kill0_occ", 32'(occupancy), 0);
    tick();
    // asynchronous reset with items in flight
    out_ready = 0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1;
      in_data = 16'hD000 + 16'(k);
      tick();
    end
    in_valid = 0;
    tick();
    check("mid_out_valid_pre", 32'(out_valid), 1);
    check("mid_occ_pre", 32'(occupancy), 3);
    #2 rst = 0;
    #1;
    check("mid_out_valid", 32'(out_valid), 0);
    check("mid_occ", 32'(occupancy), 0);
    check("mid_dropped", 32'(dropped), 0);
    check("mid_dropped_s", 32'(dropped_s), 0);
    exp_q.delete();
    tick();
    rst = 1;
    out_ready = 1;
    in_valid = 1;
    in_data = 16'h7777;
    tick();
    in_valid = 0;
    repeat (5) tick();
    @(negedge clk);
    check("post_rst_sb_empty", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
